rsa_exp_ctrl: RTL and testbench

Sequencer that computes RSA modular exponentiation M^e mod N by driving one shared Montgomery multiplier through valid/ready request and response channels. It sits between the RSA top-level job interface and the Montgomery datapath. It walks the exponent right-to-left, issuing multiply and square products one at a time, and returns the plain-domain result. Upstream supplies the message already packed into the Montgomery domain (M·2^MOD_WIDTH mod N).

---
 rtl/rsa_exp_ctrl.sv | 170 +++++++++++++++++
 tb/tb_rsa_exp_ctrl.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_exp_ctrl.sv
// Right-to-left modular exponentiation sequencer that drives one shared
// Montgomery multiplier through valid/ready request and response channels.
module rsa_exp_ctrl #(
   parameter int MOD_WIDTH = 256,
   parameter int KEY_WIDTH = MOD_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   // job request
   input  logic                 i_valid,
   output logic                 i_ready,
   input  logic [MOD_WIDTH-1:0] i_pack,
   input  logic [KEY_WIDTH-1:0] i_key,
   input  logic [MOD_WIDTH-1:0] i_modulus,
   // job result
   output logic                 o_valid,
   input  logic                 o_ready,
   output logic [MOD_WIDTH-1:0] o_result,
   // Montgomery request
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [MOD_WIDTH-1:0] m_a,
   output logic [MOD_WIDTH-1:0] m_b,
   output logic [MOD_WIDTH-1:0] m_modulus,
   // Montgomery response
   input  logic                 r_valid,
   output logic                 r_ready,
   input  logic [MOD_WIDTH-1:0] r_out
);

   localparam int IDX_W = $clog2(KEY_WIDTH + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MUL_REQ,
      S_MUL_WAIT,
      S_SQR_REQ,
      S_SQR_WAIT,
      S_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [MOD_WIDTH-1:0] result_q;
   logic [MOD_WIDTH-1:0] pack_q;
   logic [KEY_WIDTH-1:0] key_q;
   logic [MOD_WIDTH-1:0] modulus_q;
   logic [IDX_W-1:0]     idx_q;
   logic [IDX_W-1:0]     idx_inc;

   logic                 job_accept;
   logic                 mul_resp;
   logic                 sqr_resp;

   // Picks the next product for bit i; mul_done skips the multiply when the
   // multiply for this bit has already been folded into result.
   function automatic state_t decide(input logic [KEY_WIDTH-1:0] k,
                                     input logic [IDX_W-1:0]     i,
                                     input logic                 mul_done);
      logic [KEY_WIDTH-1:0] rest;
      rest = k >> i;
      if (rest[0] && !mul_done) begin
         return S_MUL_REQ;
      end else if ((rest >> 1) != '0) begin
         return S_SQR_REQ;
      end else begin
         return S_DONE;
      end
   endfunction

   assign idx_inc    = idx_q + IDX_W'(1);
   assign job_accept = i_valid && i_ready;
   assign mul_resp   = (state_q == S_MUL_WAIT) && r_valid;
   assign sqr_resp   = (state_q == S_SQR_WAIT) && r_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         // NOTE: registers take non-blocking assignments so every flop samples
         // the pre-edge values regardless of statement order.
         state_q <= state_d;
      end
   end

   always_comb begin
      // NOTE: every output is given a default first so no path through the
      // case statement leaves a signal unassigned and infers a latch.
      state_d   = state_q;
      i_ready   = 1'b0;
      o_valid   = 1'b0;
      o_result  = '0;
      m_valid   = 1'b0;
      m_a       = '0;
      m_b       = '0;
      m_modulus = '0;
      r_ready   = 1'b0;

      case (state_q)
         S_IDLE: begin
            i_ready = 1'b1;
            if (i_valid) begin
               state_d = decide(i_key, '0, 1'b0);
            end
         end
         S_MUL_REQ: begin
            m_valid   = 1'b1;
            m_a       = result_q;
            m_b       = pack_q;
            m_modulus = modulus_q;
            if (m_ready) begin
               state_d = S_MUL_WAIT;
            end
         end
         S_MUL_WAIT: begin
            r_ready = 1'b1;
            if (r_valid) begin
               state_d = decide(key_q, idx_q, 1'b1);
            end
         end
         S_SQR_REQ: begin
            m_valid   = 1'b1;
            m_a       = pack_q;
            m_b       = pack_q;
            m_modulus = modulus_q;
            if (m_ready) begin
               state_d = S_SQR_WAIT;
            end
         end
         S_SQR_WAIT: begin
            r_ready = 1'b1;
            if (r_valid) begin
               state_d = decide(key_q, idx_inc, 1'b0);
            end
         end
         S_DONE: begin
            o_valid  = 1'b1;
            o_result = result_q;
            if (o_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Operand registers; Montgomery products are stored exactly as returned.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q  <= '0;
         pack_q    <= '0;
         key_q     <= '0;
         modulus_q <= '0;
         idx_q     <= '0;
      end else if (job_accept) begin
         result_q  <= MOD_WIDTH'(1);
         pack_q    <= i_pack;
         key_q     <= i_key;
         modulus_q <= i_modulus;
         idx_q     <= '0;
      end else if (mul_resp) begin
         result_q  <= r_out;
      end else if (sqr_resp) begin
         pack_q    <= r_out;
         idx_q     <= idx_inc;
      end
   end

endmodule

// File: tb/tb_rsa_exp_ctrl.sv
// Self-checking bench for rsa_exp_ctrl at 8-bit width with a behavioural
// Montgomery multiplier (R = 256) and a plain-arithmetic reference model.
module tb_rsa_exp_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         i_valid, i_ready;
   logic [W-1:0] i_pack, i_key, i_modulus;
   logic         o_valid, o_ready;
   logic [W-1:0] o_result;
   logic         m_valid, m_ready;
   logic [W-1:0] m_a, m_b, m_modulus;
   logic         r_valid, r_ready;
   logic [W-1:0] r_out;

   always #5 clk = ~clk;

   rsa_exp_ctrl #(.MOD_WIDTH(W), .KEY_WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_valid   (i_valid),
      .i_ready   (i_ready),
      .i_pack    (i_pack),
      .i_key     (i_key),
      .i_modulus (i_modulus),
      .o_valid   (o_valid),
      .o_ready   (o_ready),
      .o_result  (o_result),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_a       (m_a),
      .m_b       (m_b),
      .m_modulus (m_modulus),
      .r_valid   (r_valid),
      .r_ready   (r_ready),
      .r_out     (r_out)
   );

   typedef struct {
      int a;
      int b;
   } req_t;

   int   tests = 0;
   int   fails = 0;

   // job under test and reference model state
   int   cur_n, cur_m, cur_key;
   req_t exp_q[$];
   req_t log_q[$];
   int   act_res = 0;
   int   req_cnt = 0;
   int   done_cnt = 0;
   bit   exp_idle = 1'b1;
   bit   outstanding = 1'b0;
   bit   just_acc = 1'b0;

   // environment knobs
   bit   bp_en = 1'b0;
   bit   m_force = 1'b0;
   bit   o_force = 1'b0;
   int   lat_max = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // a*b*R^-1 mod n, found by search so it does not depend on REDC tricks
   function automatic int mont(input int a, input int b, input int n);
      int p;
      p = (a * b) % n;
      for (int t = 0; t < n; t++) begin
         if ((t * 256) % n == p) return t;
      end
      return 0;
   endfunction

   function automatic int modexp(input int m, input int e, input int n);
      int r;
      r = 1;
      for (int i = 0; i < e; i++) r = (r * m) % n;
      return r;
   endfunction

   function automatic int exp_requests(input int key);
      int pc, msb;
      pc  = 0;
      msb = 0;
      for (int i = 0; i < W; i++) begin
         if (((key >> i) & 1) != 0) begin
            pc++;
            msb = i;
         end
      end
      return pc + msb;
   endfunction

   // Expected request stream in plain-domain terms: multiplies fold M^(2^i)
   // into the running product, squares advance M^(2^i) while higher bits remain.
   task automatic build_model();
      int r, p, pm;
      exp_q.delete();
      r = 1;
      p = cur_m;
      for (int i = 0; i < W; i++) begin
         pm = (p * 256) % cur_n;
         if (((cur_key >> i) & 1) != 0) begin
            exp_q.push_back('{r, pm});
            r = (r * p) % cur_n;
         end
         if ((cur_key >> (i + 1)) != 0) begin
            exp_q.push_back('{pm, pm});
            p = (p * p) % cur_n;
         end
      end
   endtask

   // Compare process: every cycle out of reset, at the falling edge.
   initial begin : monitor
      bit         prev_mv, prev_mr, prev_ov, prev_or;
      logic [W-1:0] prev_a, prev_b, prev_n, prev_res;
      req_t       e;
      prev_mv = 0; prev_mr = 0; prev_ov = 0; prev_or = 0;
      prev_a = 0; prev_b = 0; prev_n = 0; prev_res = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            exp_q.delete();
            exp_idle    = 1'b1;
            outstanding = 1'b0;
            just_acc    = 1'b0;
            prev_mv     = 1'b0;
            prev_ov     = 1'b0;
         end else begin
            check("i_ready", i_ready, exp_idle);
            check("r_ready", r_ready, outstanding);
            if (just_acc) check("req_or_done_after_accept", m_valid | o_valid, 1);
            just_acc = 1'b0;
            if (prev_mv && !prev_mr) begin
               check("m_valid_stable", m_valid, 1);
               check("m_a_stable", m_a, prev_a);
               check("m_b_stable", m_b, prev_b);
               check("m_modulus_stable", m_modulus, prev_n);
            end
            if (prev_ov && !prev_or) begin
               check("o_valid_stable", o_valid, 1);
               check("o_result_stable", o_result, prev_res);
            end
            if (m_valid && m_ready) begin
               req_cnt++;
               log_q.push_back('{int'(m_a), int'(m_b)});
               if (exp_q.size() == 0) begin
                  check("unexpected_request", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("m_a", m_a, e.a);
                  check("m_b", m_b, e.b);
                  check("m_modulus", m_modulus, cur_n);
               end
               outstanding = 1'b1;
            end
            if (r_valid && r_ready) outstanding = 1'b0;
            if (o_valid && o_ready) begin
               act_res = int'(o_result);
               check("requests_left_at_done", exp_q.size(), 0);
               done_cnt++;
               exp_idle = 1'b1;
            end
            if (i_valid && i_ready) begin
               build_model();
               req_cnt  = 0;
               log_q.delete();
               exp_idle = 1'b0;
               just_acc = 1'b1;
            end
            prev_mv = m_valid; prev_mr = m_ready;
            prev_a = m_a; prev_b = m_b; prev_n = m_modulus;
            prev_ov = o_valid; prev_or = o_ready; prev_res = o_result;
         end
      end
   end

   // Behavioural Montgomery multiplier with random latency and backpressure.
   initial begin : mult_model
      bit mh, rh, busy;
      int lat, pa, pb, pn;
      logic [W-1:0] sa, sb, sn;
      m_ready = 1'b0;
      r_valid = 1'b0;
      r_out   = '0;
      busy    = 1'b0;
      lat     = 0;
      pa = 0; pb = 0; pn = 1;
      forever begin
         @(negedge clk);
         mh = m_valid && m_ready;
         rh = r_valid && r_ready;
         sa = m_a; sb = m_b; sn = m_modulus;
         @(posedge clk);
         #1;
         if (!rst_n) begin
            busy    = 1'b0;
            r_valid = 1'b0;
         end else begin
            if (rh) r_valid = 1'b0;
            if (mh) begin
               busy = 1'b1;
               lat  = $urandom_range(0, lat_max);
               pa = int'(sa); pb = int'(sb); pn = int'(sn);
            end
            if (busy && !r_valid) begin
               if (lat == 0) begin
                  r_valid = 1'b1;
                  r_out   = W'(mont(pa, pb, pn));
                  busy    = 1'b0;
               end else begin
                  lat--;
               end
            end
         end
         m_ready = m_force ? 1'b0 : (bp_en ? ($urandom_range(0, 3) != 0) : 1'b1);
      end
   end

   initial begin : result_sink
      o_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         o_ready = o_force ? 1'b0 : (bp_en ? 1'($urandom_range(0, 1)) : 1'b1);
      end
   end

   // Raises a job and returns 1 time unit after the accepting edge.
   task automatic start_job(input int n, input int m, input int key);
      bit ok;
      cur_n   = n;
      cur_m   = m;
      cur_key = key;
      i_pack    = W'((m * 256) % n);
      i_key     = W'(key);
      i_modulus = W'(n);
      i_valid   = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (i_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("accept_timeout", 0, 1);
      @(posedge clk);
      #1;
      i_valid = 1'b0;
   endtask

   task automatic wait_done();
      int  start;
      bit  ok;
      start = done_cnt;
      ok    = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk);
         #2;
         if (done_cnt != start) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("done_timeout", 0, 1);
   endtask

   task automatic run_job(input int n, input int m, input int key);
      start_job(n, m, key);
      wait_done();
      check("result", act_res, modexp(m, key, n));
      check("request_count", req_cnt, exp_requests(key));
   endtask

   initial begin : main
      bit ok;
      rst_n     = 1'b0;
      i_valid   = 1'b0;
      i_pack    = '0;
      i_key     = '0;
      i_modulus = '0;
      cur_n = 13; cur_m = 0; cur_key = 0;
      #1;
      check("rst_i_ready", i_ready, 1);
      check("rst_o_valid", o_valid, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_r_ready", r_ready, 0);
      check("rst_o_result", o_result, 0);
      check("rst_m_a", m_a, 0);
      check("rst_m_b", m_b, 0);
      check("rst_m_modulus", m_modulus, 0);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;

      // key = 5, N = 13, M = 2: hand-worked request stream and result
      lat_max = 2;
      run_job(13, 2, 5);
      check("k5_result_literal", act_res, 6);
      check("k5_req_count_literal", req_cnt, 4);
      if (log_q.size() == 4) begin
         check("k5_req0_a", log_q[0].a, 1);  check("k5_req0_b", log_q[0].b, 5);
         check("k5_req1_a", log_q[1].a, 5);  check("k5_req1_b", log_q[1].b, 5);
         check("k5_req2_a", log_q[2].a, 10); check("k5_req2_b", log_q[2].b, 10);
         check("k5_req3_a", log_q[3].a, 2);  check("k5_req3_b", log_q[3].b, 1);
      end else begin
         check("k5_log_size", log_q.size(), 4);
      end

      // key = 0: done right after accept, no multiplier traffic
      start_job(37, 9, 0);
      check("k0_o_valid_t1", o_valid, 1);
      check("k0_o_result_t1", o_result, 1);
      check("k0_m_valid_t1", m_valid, 0);
      wait_done();
      check("k0_result", act_res, 1);
      check("k0_requests", req_cnt, 0);

      // key = 255: ord(2) mod 13 is 12, so 2^255 = 2^3 = 8
      run_job(13, 2, 255);
      check("k255_result_literal", act_res, 8);
      check("k255_req_count_literal", req_cnt, 15);

      // request and result backpressure on the key = 5 job
      m_force = 1'b1;
      o_force = 1'b1;
      start_job(13, 2, 5);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("stall_m_valid", m_valid, 1);
         check("stall_m_a", m_a, 1);
         check("stall_m_b", m_b, 5);
         check("stall_i_ready", i_ready, 0);
      end
      m_force = 1'b0;
      ok = 1'b0;
      for (int c = 0; c < 500; c++) begin
         @(negedge clk);
         if (o_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("stall_o_valid_timeout", 0, 1);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("stall_o_valid", o_valid, 1);
         check("stall_o_result", o_result, 6);
         check("stall_o_i_ready", i_ready, 0);
      end
      o_force = 1'b0;
      wait_done();
      check("stall_result", act_res, 6);

      // reset during the first square wait, then a clean key = 5 job
      lat_max = 4;
      start_job(13, 2, 5);
      ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(posedge clk);
         #2;
         if (req_cnt >= 2) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("sqr_wait_timeout", 0, 1);
      check("pre_reset_r_ready", r_ready, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_i_ready", i_ready, 1);
      check("mid_rst_o_valid", o_valid, 0);
      check("mid_rst_m_valid", m_valid, 0);
      check("mid_rst_r_ready", r_ready, 0);
      check("mid_rst_o_result", o_result, 0);
      check("mid_rst_m_a", m_a, 0);
      check("mid_rst_m_b", m_b, 0);
      check("mid_rst_m_modulus", m_modulus, 0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      run_job(13, 2, 5);
      check("post_rst_result", act_res, 6);

      // random jobs with random latency and backpressure
      bp_en   = 1'b1;
      lat_max = 3;
      for (int j = 0; j < 200; j++) begin
         int n, m, k;
         n = 2 * $urandom_range(1, 127) + 1;
         m = $urandom_range(0, n - 1);
         k = $urandom_range(0, 255);
         run_job(n, m, k);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
